eval_sequencer: RTL
===================

# eval_sequencer

Reduction sequencer for the calculator's operand/operator stacks. On each `req` pulse it pops two operands and one operator, evaluates them in an internal ALU, and pushes the result back onto the operand stack. It reports completion or a fault back to the main parse controller. It replaces the open-coded pop/compute/push state chains in the parse controller with one handshaked block.

## Interface
- `WIDTH`, 16, operand/result width in bits.
- `clk`  in  1  system clock; all state is updated on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  1  start one reduction; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a reduction ends, whether it succeeded or failed.
- `err`  out  1  one-cycle pulse coincident with `done` when the reduction failed.
- `err_code`  out  2  fault code: 0 none, 1 operand underflow, 2 operator underflow, 3 divide-by-zero or illegal op. Holds its value until the next `req` is accepted.
- `opnd_empty`  in  1  operand stack is empty.
- `opnd_dout`  in  WIDTH  operand stack top; valid while not empty.
- `opnd_pop`  out  1  operand pop strobe.
- `opnd_push`  out  1  operand push strobe.
- `opnd_din`  out  WIDTH  data to push.
- `oper_empty`  in  1  operator stack is empty.
- `oper_dout`  in  2  operator stack top: 00 add, 01 sub, 10 mul, 11 div.
- `oper_pop`  out  1  operator pop strobe.
- `last_result`  out  WIDTH  last value pushed; feeds the display.

## Operation
- States: IDLE, POP_B, POP_A, POP_OP, EXEC, DIV, PUSH, FIN, ERR.
- **IDLE**: if `req`, clear `err_code` and go to POP_B. Otherwise stay in IDLE.
- **POP_B**:
  - If `opnd_empty`, set `err_code`=1 and go to ERR.
  - Otherwise latch b=`opnd_dout`, assert `opnd_pop`, and go to POP_A.
- **POP_A**: same as POP_B, but latch a=`opnd_dout`.
- **POP_OP**:
  - If `oper_empty`, set `err_code`=2 and go to ERR.
  - Otherwise latch op=`oper_dout`, assert `oper_pop`, and go to EXEC.
- **EXEC**:
  - add: r=a+b.
  - sub: r=a-b.
  - mul: r = low WIDTH bits of a*b.
  - All three are unsigned and modulo 2^WIDTH; each then goes to PUSH.
  - div with b==0: `err_code`=3, go to ERR.
  - div with b!=0: initialise the divider and go to DIV.
- **DIV**: unsigned restoring division, one quotient bit per cycle, exactly WIDTH cycles. r = quotient (remainder is discarded). Then go to PUSH.
- **PUSH**: assert `opnd_push` with `opnd_din`=r, update `last_result`=r, go to FIN.
- **FIN**: assert `done`, go to IDLE.
- **ERR**: assert `done` and `err`, go to IDLE.
  - No push is issued on error.
  - Pops already performed are not restored; the parse controller must flush the expression.
- Stack strobes are one cycle wide, and at most one strobe is active per cycle. Stack data reflects the new top in the cycle after a pop.

## Timing
- Reset values:
  - state IDLE.
  - `busy`, `done`, `err`, `opnd_pop`, `opnd_push`, `oper_pop` all 0.
  - `err_code`=0, `opnd_din`=0, `last_result`=0.
- Take cycle 0 as the cycle in which `req` is sampled in IDLE. Then:
  - `opnd_pop` in cycles 1 and 2; `oper_pop` in cycle 3.
  - add/sub/mul: `opnd_push` in cycle 5, `done` in cycle 6.
  - div: `opnd_push` in cycle 5+WIDTH, `done` in cycle 6+WIDTH.
  - Underflow at POP_B: `done`/`err` in cycle 2.
- `req` outside IDLE, including the FIN and ERR cycles, is ignored and not queued.
- A reset mid-operation returns the block to IDLE immediately. Any strobe in flight is dropped, and latched operands are discarded.
- Next `req` acceptance is earliest one cycle after `done`.

## Configuration
- `EVAL_DIV_EN` defined: divide path and DIV state are compiled in, as described above.
- `EVAL_DIV_EN` undefined: the DIV state and divider are removed.
  - opcode 11 in EXEC produces `err_code`=3, then ERR.
  - Worst-case latency is 6 cycles.

## Test plan
- Stack [a=7, b=5] with op add; `req` -> `opnd_pop` in cycles 1–2, `oper_pop` in cycle 3, push 12 in cycle 5, `done` in cycle 6, `err`=0, `last_result`=12.
- a=3, b=5, sub, WIDTH=16 -> push 0xFFFE; a=0x0100, b=0x0100, mul -> push 0x0000 (wrap).
- With `EVAL_DIV_EN`: a=100, b=7, div -> push 14, `done` in cycle 22. With b=0 -> `err_code`=3 and no push. Without the macro, div -> `err_code`=3 in cycle 5.
- Operand stack holding one entry; `req` -> one `opnd_pop` in cycle 1, `err_code`=1, `done`+`err` in cycle 3. Empty operator stack -> `err_code`=2.
- `req` held high throughout an add -> exactly one reduction per IDLE visit, with the second accepted in cycle 7. Assert `rst` in cycle 3 -> all outputs 0, no push, and `busy` low immediately.

Source files
------------

// File: rtl/eval_sequencer.sv
// Reduction sequencer: pops operand b, operand a and an operator, evaluates, pushes the result.
// Define EVAL_DIV_EN to compile in the restoring divider; without it opcode 11 faults with code 3.
module eval_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    input  logic             opnd_empty,
    input  logic [WIDTH-1:0] opnd_dout,
    output logic             opnd_pop,
    output logic             opnd_push,
    output logic [WIDTH-1:0] opnd_din,
    input  logic             oper_empty,
    input  logic [1:0]       oper_dout,
    output logic             oper_pop,
    output logic [WIDTH-1:0] last_result
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_POP_B,
        S_POP_A,
        S_POP_OP,
        S_EXEC,
`ifdef EVAL_DIV_EN
        S_DIV,
`endif
        S_PUSH,
        S_FIN,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [WIDTH-1:0] last_q, last_d;

`ifdef EVAL_DIV_EN
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    // a_q doubles as the dividend/quotient shift register during DIV.
    assign div_shift = {rem_q, a_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_q};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 2'b00;
            r_q        <= '0;
            err_code_q <= 2'd0;
            last_q     <= '0;
`ifdef EVAL_DIV_EN
            rem_q      <= '0;
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            r_q        <= r_d;
            err_code_q <= err_code_d;
            last_q     <= last_d;
`ifdef EVAL_DIV_EN
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        r_d        = r_q;
        err_code_d = err_code_q;
        last_d     = last_q;
`ifdef EVAL_DIV_EN
        rem_d      = rem_q;
        cnt_d      = cnt_q;
`endif
        busy       = (state_q != S_IDLE);
        done       = 1'b0;
        err        = 1'b0;
        opnd_pop   = 1'b0;
        opnd_push  = 1'b0;
        oper_pop   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    err_code_d = 2'd0;
                    state_d    = S_POP_B;
                end
            end
            S_POP_B: begin
                if (opnd_empty) begin
                    err_code_d = 2'd1;
                    state_d    = S_ERR;
                end else begin
                    b_d      = opnd_dout;
                    opnd_pop = 1'b1;
                    state_d  = S_POP_A;
                end
            end
            S_POP_A: begin
                if (opnd_empty) begin
                    err_code_d = 2'd1;
                    state_d    = S_ERR;
                end else begin
                    a_d      = opnd_dout;
                    opnd_pop = 1'b1;
                    state_d  = S_POP_OP;
                end
            end
            S_POP_OP: begin
                if (oper_empty) begin
                    err_code_d = 2'd2;
                    state_d    = S_ERR;
                end else begin
                    op_d     = oper_dout;
                    oper_pop = 1'b1;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op_q)
                    2'b00: begin r_d = a_q + b_q; state_d = S_PUSH; end
                    2'b01: begin r_d = a_q - b_q; state_d = S_PUSH; end
                    2'b10: begin r_d = a_q * b_q; state_d = S_PUSH; end
                    default: begin
`ifdef EVAL_DIV_EN
                        if (b_q == '0) begin
                            err_code_d = 2'd3;
                            state_d    = S_ERR;
                        end else begin
                            rem_d   = '0;
                            cnt_d   = '0;
                            state_d = S_DIV;
                        end
`else
                        err_code_d = 2'd3;
                        state_d    = S_ERR;
`endif
                    end
                endcase
            end
`ifdef EVAL_DIV_EN
            S_DIV: begin
                if (!div_diff[WIDTH]) begin
                    rem_d = div_diff[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = div_shift[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    r_d     = a_d;
                    state_d = S_PUSH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_PUSH: begin
                opnd_push = 1'b1;
                last_d    = r_q;
                state_d   = S_FIN;
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                done    = 1'b1;
                err     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign err_code    = err_code_q;
    assign opnd_din    = r_q;
    assign last_result = last_q;

endmodule
